// File: rtl/ltc_serial_pkg.sv
// Shared definitions for the LTC serial link: line-state encoding,
// bit-period derivation and frame-length constants.
package ltc_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_GAP
    } serial_state_e;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;  // start + 8 data + stop

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned frame_cycles(input int unsigned div,
                                                 input int unsigned gap_bits);
        return (FRAME_BITS + gap_bits) * div;
    endfunction

    function automatic int unsigned packet_cycles(input int unsigned div,
                                                  input int unsigned gap_bits,
                                                  input int unsigned nbytes);
        return nbytes * frame_cycles(div, gap_bits);
    endfunction

endpackage

// File: rtl/work_serial_sender_timer.sv
// Bit-period timer: counts 0..DIV-1 while run is high and flags the last
// cycle of each bit period; held at zero when idle.
module uart_bit_timer #(
    parameter int unsigned DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            count <= '0;
        end else if (count == CW'(DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = run && (count == CW'(DIV - 1));

endmodule

// File: rtl/work_serial_sender.sv
// Serialises a latched work packet onto an 8N1 UART line, one byte per
// frame, with optional idle-high gap bits after every stop bit.
module work_serial_sender
    import ltc_serial_pkg::*;
#(
    parameter int unsigned COMM_CLK_FREQUENCY = 1_000_000,
    parameter int unsigned BAUD_RATE          = 115_200,
    parameter int unsigned PAYLOAD_BYTES      = 84,
    parameter int unsigned BYTE_ORDER         = 0,
    parameter int unsigned GAP_BITS           = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    input  logic                       send,
    output logic                       ready,
    output logic                       TxD,
    output logic [7:0]                 byte_idx,
    output logic                       done
);

    localparam int unsigned DIV = calc_div(COMM_CLK_FREQUENCY, BAUD_RATE);
    localparam int unsigned PW  = 8 * PAYLOAD_BYTES;
    localparam int unsigned GW  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    serial_state_e state, state_n;
    logic [PW-1:0] shreg, shreg_n;
    logic [7:0]    cur, cur_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    byte_cnt, byte_cnt_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic          done_n;
    logic          frame_end;
    logic          tick;

    uart_bit_timer #(
        .DIV(DIV)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .run  (state != ST_IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            cur      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            cur      <= cur_n;
            bit_cnt  <= bit_cnt_n;
            byte_cnt <= byte_cnt_n;
            gap_cnt  <= gap_cnt_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        cur_n      = cur;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        gap_cnt_n  = gap_cnt;
        done_n     = 1'b0;
        frame_end  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (send) begin
                    shreg_n    = payload;
                    byte_cnt_n = '0;
                    bit_cnt_n  = '0;
                    state_n    = ST_START;
                end
            end
            ST_START: begin
                // Byte is pulled off the packet at the end of the start bit.
                if (tick) begin
                    if (BYTE_ORDER != 0) begin
                        cur_n   = shreg[7:0];
                        shreg_n = shreg >> 8;
                    end else begin
                        cur_n   = shreg[PW-1 -: 8];
                        shreg_n = shreg << 8;
                    end
                    bit_cnt_n = '0;
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    cur_n = cur >> 1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = ST_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (GAP_BITS > 0) begin
                        gap_cnt_n = '0;
                        state_n   = ST_GAP;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_cnt == GW'(GAP_BITS - 1)) begin
                        frame_end = 1'b1;
                    end else begin
                        gap_cnt_n = gap_cnt + GW'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (frame_end) begin
            if (byte_cnt == 8'(PAYLOAD_BYTES - 1)) begin
                byte_cnt_n = '0;
                done_n     = 1'b1;
                state_n    = ST_IDLE;
            end else begin
                byte_cnt_n = byte_cnt + 8'd1;
                state_n    = ST_START;
            end
        end
    end

    always_comb begin
        TxD = 1'b1;
        case (state)
            ST_START: TxD = 1'b0;
            ST_DATA:  TxD = cur[0];
            default:  TxD = 1'b1;
        endcase
    end

    assign ready    = (state == ST_IDLE);
    assign byte_idx = byte_cnt;

endmodule
